// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter driving the single write port of an edge-triggered fifo.
// Define FIFO_WRITE_ARB_STATS_EN to build the saturating stall_count counter.
module fifo_write_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic [15:0]                   stall_count
);

  typedef enum logic {
    IDLE,
    STROBE
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [IDW-1:0]        last;
  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  accept;

  // cyclic search starting just after the last winner
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
        win_data  = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (win_found && !fifo_full) begin
          accept             = 1'b1;
          req_ready[win_idx] = 1'b1;
          state_n            = STROBE;
        end
      end
      STROBE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_write_en <= 1'b0;
      fifo_data_in  <= '0;
      grant_id      <= '0;
      last          <= IDW'(NUM_REQ - 1);
    end else begin
      fifo_write_en <= accept;
      if (accept) begin
        fifo_data_in <= win_data;
        grant_id     <= win_idx;
        last         <= win_idx;
      end
    end
  end

  assign busy = (state == STROBE);

`ifdef FIFO_WRITE_ARB_STATS_EN
  logic stall;

  assign stall = (state == IDLE) && (|req_valid) && fifo_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= 16'h0000;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a small behavioural depth-16 fifo.
// Expected stall_count follows FIFO_WRITE_ARB_STATS_EN.
module tb_fifo_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] stall_count;

  logic        full_force = 1'b0;
  logic        model_on = 1'b0;
  int          wr_count = 0;
  int          wr_base = 0;
  logic [7:0]  log_data[$];
  logic [1:0]  log_gid[$];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_write_en(fifo_write_en),
    .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full),
    .grant_id(grant_id),
    .busy(busy),
    .stall_count(stall_count)
  );

  // fifo model: one word per write_en pulse, sampled mid-pulse
  always @(negedge clock) begin
    if (fifo_write_en) begin
      log_data.push_back(fifo_data_in);
      log_gid.push_back(grant_id);
      wr_count <= wr_count + 1;
    end
  end

  assign fifo_full = full_force | (model_on && (wr_count - wr_base >= 16));

  task automatic do_reset();
    @(negedge clock);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_write_en !== 1'b0 || fifo_data_in !== 8'h00 || grant_id !== 2'd0
        || busy !== 1'b0 || stall_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: wen=%b data=%h gid=%0d busy=%b stall=%0d want all 0",
               fifo_write_en, fifo_data_in, grant_id, busy, stall_count);
    end
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_write_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_single_producer();
    req_data = 32'h00A5_0000;
    req_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0100 || fifo_write_en !== 1'b0) begin
        errors++;
        $display("FAIL single_idle[%0d]: ready=%b wen=%b want 0100 0", n, req_ready,
                 fifo_write_en);
      end
      @(negedge clock);
      #1;
      checks++;
      if (fifo_write_en !== 1'b1 || fifo_data_in !== 8'hA5 || grant_id !== 2'd2
          || busy !== 1'b1 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL single_strobe[%0d]: wen=%b data=%h gid=%0d busy=%b ready=%b want 1 a5 2 1 0000",
                 n, fifo_write_en, fifo_data_in, grant_id, busy, req_ready);
      end
      @(negedge clock);
    end
    req_valid = '0;
    #1;
    checks++;
    if (fifo_write_en !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL single_drop: wen=%b ready=%b want 0 0000", fifo_write_en, req_ready);
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [7:0] exp_d[5];
    logic [1:0] exp_g[5];
    exp_d = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    base = log_data.size();
    req_data = 32'h3322_1100;
    req_valid = 4'hF;
    repeat (10) @(negedge clock);
    req_valid = '0;
    #1;
    checks++;
    if (log_data.size() - base != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d writes want 5", log_data.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_data[base+i] !== exp_d[i] || log_gid[base+i] !== exp_g[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: data=%h gid=%0d want %h %0d", i,
                   log_data[base+i], log_gid[base+i], exp_d[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    int bad;
    logic [15:0] exp_stall;
`ifdef FIFO_WRITE_ARB_STATS_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    do_reset();
    full_force = 1'b1;
    req_valid = 4'hF;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready !== 4'b0 || fifo_write_en !== 1'b0) bad++;
      @(negedge clock);
    end
    req_valid = '0;
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_block: %0d cycles with ready/pulse, want 0", bad);
    end
    checks++;
    if (stall_count !== exp_stall) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", stall_count, exp_stall);
    end
    full_force = 1'b0;
  endtask

  task automatic test_fill_fifo();
    int acc;
    do_reset();
    wr_base = wr_count;
    model_on = 1'b1;
    acc = 0;
    req_data = '0;
    req_valid = 4'b0001;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (req_ready[0]) acc++;
      @(negedge clock);
      req_data[7:0] = 8'(acc);
      req_valid[0] = (acc < 20);
    end
    #1;
    checks++;
    if (acc != 16 || wr_count - wr_base != 16) begin
      errors++;
      $display("FAIL fill_accept: accepted=%0d written=%0d want 16 16", acc,
               wr_count - wr_base);
    end
    checks++;
    if (fifo_full !== 1'b1 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b ready=%b want 1 0000", fifo_full, req_ready);
    end
    checks++;
    if (log_data[log_data.size()-1] !== 8'd15) begin
      errors++;
      $display("FAIL fill_last: got %h want 0f", log_data[log_data.size()-1]);
    end
    req_valid = '0;
    model_on = 1'b0;
  endtask

  task automatic test_reset_in_strobe();
    int cnt0;
    do_reset();
    req_data = 32'h4433_2211;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_pre_ready: got %b want 0010", req_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (fifo_write_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_pulse: wen=%b want 1", fifo_write_en);
    end
    cnt0 = wr_count;
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_write_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_cut: wen=%b busy=%b want 0 0", fifo_write_en, busy);
    end
    @(negedge clock);
    #1;
    checks++;
    if (wr_count != cnt0) begin
      errors++;
      $display("FAIL rst_count: got %0d want %0d", wr_count, cnt0);
    end
    req_valid = 4'hF;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_priority: got %b want 0001", req_ready);
    end
    @(negedge clock);
    req_valid = '0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_producer();
    test_round_robin();
    test_full_stall();
    test_fill_fifo();
    test_reset_in_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
